// File: rtl/propagation_monitor_if.sv
// Signal bundle between the pulser/timer front end and the propagation monitor.
// The master side drives the stimulus; the slave side is the monitor itself.
interface propagation_monitor_if;
  logic        Pulser_Trigger_Request;
  logic        Pulse_Measurement_Done;
  logic [15:0] Pulse_Propagation_Counter;
  logic        Pulser_IC_Error;
  logic [15:0] Low_Limit;
  logic [15:0] High_Limit;
  logic        Stats_Clear;
  logic [15:0] Avg_Propagation;
  logic        Avg_Valid;
  logic [15:0] Min_Propagation;
  logic [15:0] Max_Propagation;
  logic [15:0] Sample_Count;
  logic        Window_Error;
  logic        Timeout_Error;
  logic        Busy;

  modport master (
    output Pulser_Trigger_Request, Pulse_Measurement_Done, Pulse_Propagation_Counter,
           Pulser_IC_Error, Low_Limit, High_Limit, Stats_Clear,
    input  Avg_Propagation, Avg_Valid, Min_Propagation, Max_Propagation, Sample_Count,
           Window_Error, Timeout_Error, Busy
  );

  modport slave (
    input  Pulser_Trigger_Request, Pulse_Measurement_Done, Pulse_Propagation_Counter,
           Pulser_IC_Error, Low_Limit, High_Limit, Stats_Clear,
    output Avg_Propagation, Avg_Valid, Min_Propagation, Max_Propagation, Sample_Count,
           Window_Error, Timeout_Error, Busy
  );
endinterface

// File: rtl/propagation_monitor.sv
// Captures one propagation count per trigger, filters it against a window and keeps
// running min/max/count plus a block average over 2**AVG_LOG2 accepted samples.
module propagation_monitor #(
  parameter int unsigned AVG_LOG2       = 3,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input logic                   clk,
  input logic                   reset,
  propagation_monitor_if.slave  bus
);

  localparam int unsigned AccW = 16 + AVG_LOG2;
  localparam int unsigned BlkW = AVG_LOG2 + 1;
  localparam logic [BlkW-1:0] BlkFull = BlkW'(1 << AVG_LOG2);
  localparam logic [15:0] TimeoutLast = TIMEOUT_CYCLES - 16'd1;

  typedef enum logic [1:0] {StIdle, StWaitDone, StCapture} state_e;

  state_e          state_q, state_d;
  logic [15:0]     tmo_q, tmo_d;
  logic            trig_q, done_q;
  logic            trig_rise, done_rise, timeout_set;

  logic [AccW-1:0] acc_q, acc_d, acc_sum;
  logic [BlkW-1:0] blk_q, blk_d, blk_inc;
  logic [15:0]     cnt_q, cnt_d, min_q, min_d, max_q, max_d, avg_q, avg_d;
  logic            avg_valid_q, avg_valid_d, win_err_q, win_err_d, tmo_err_q, tmo_err_d;
  logic [15:0]     sample;
  logic            capture, in_window, accept, block_done;

  assign trig_rise = bus.Pulser_Trigger_Request & ~trig_q;
  assign done_rise = bus.Pulse_Measurement_Done & ~done_q;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trig_rise) begin
          state_d = StWaitDone;
          tmo_d   = '0;
        end
      end
      StWaitDone: begin
        tmo_d = tmo_q + 16'd1;
        if (bus.Pulser_IC_Error) begin
          state_d = StIdle;
        end else if (done_rise) begin
          state_d = StCapture;
        end else if (trig_rise) begin
          tmo_d = '0;
        end else if (tmo_q == TimeoutLast) begin
          state_d     = StIdle;
          timeout_set = 1'b1;
        end
      end
      StCapture: begin
        // A fresh trigger arriving during the capture cycle starts the next measurement.
        if (trig_rise) begin
          state_d = StWaitDone;
          tmo_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign sample     = bus.Pulse_Propagation_Counter;
  assign capture    = (state_q == StCapture);
  assign in_window  = (sample >= bus.Low_Limit) && (sample <= bus.High_Limit);
  assign accept     = capture && in_window && !bus.Stats_Clear;
  assign acc_sum    = acc_q + AccW'(sample);
  assign blk_inc    = blk_q + BlkW'(1);
  assign block_done = accept && (blk_inc == BlkFull);

  always_comb begin
    acc_d       = acc_q;
    blk_d       = blk_q;
    cnt_d       = cnt_q;
    min_d       = min_q;
    max_d       = max_q;
    avg_d       = avg_q;
    avg_valid_d = block_done;
    // Flag-setting events beat a same-cycle clear.
    win_err_d   = (win_err_q & ~bus.Stats_Clear) | (capture & ~in_window);
    tmo_err_d   = (tmo_err_q & ~bus.Stats_Clear) | timeout_set;
    if (bus.Stats_Clear) begin
      acc_d = '0;
      blk_d = '0;
      cnt_d = '0;
      min_d = 16'hFFFF;
      max_d = 16'h0000;
    end else if (accept) begin
      if (block_done) begin
        acc_d = '0;
        blk_d = '0;
        avg_d = acc_sum[AccW-1:AVG_LOG2];
      end else begin
        acc_d = acc_sum;
        blk_d = blk_inc;
      end
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      if (sample < min_q) min_d = sample;
      if (sample > max_q) max_d = sample;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      tmo_q       <= '0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
      acc_q       <= '0;
      blk_q       <= '0;
      cnt_q       <= '0;
      min_q       <= 16'hFFFF;
      max_q       <= 16'h0000;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      win_err_q   <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      trig_q      <= bus.Pulser_Trigger_Request;
      done_q      <= bus.Pulse_Measurement_Done;
      acc_q       <= acc_d;
      blk_q       <= blk_d;
      cnt_q       <= cnt_d;
      min_q       <= min_d;
      max_q       <= max_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      win_err_q   <= win_err_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign bus.Avg_Propagation = avg_q;
  assign bus.Avg_Valid       = avg_valid_q;
  assign bus.Min_Propagation = min_q;
  assign bus.Max_Propagation = max_q;
  assign bus.Sample_Count    = cnt_q;
  assign bus.Window_Error    = win_err_q;
  assign bus.Timeout_Error   = tmo_err_q;
  assign bus.Busy            = (state_q == StWaitDone);

endmodule

// File: doc/propagation_monitor.md
PROPAGATION_MONITOR -- requirements
Module: propagation_monitor

Interface
REQ-001 Parameter AVG_LOG2, default 3, meaning: log2 of samples per average block (legal 0..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd50000, meaning: clk cycles allowed from trigger to measurement done.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Pulser_Trigger_Request  input  1  trigger level from pulser control; rising edge starts a measurement.
REQ-006 Pulse_Measurement_Done  input  1  level from upstream propagation timer; rising edge marks a valid count.
REQ-007 Pulse_Propagation_Counter  input  16  propagation time in clk cycles; stable whenever Done is high.
REQ-008 Pulser_IC_Error  input  1  pulser fault level; aborts the current measurement.
REQ-009 Low_Limit / High_Limit  input  16 each  inclusive acceptance window for single samples.
REQ-010 Stats_Clear  input  1  synchronous one-cycle clear of statistics and sticky flags.
REQ-011 Avg_Propagation  output  16  last completed block average.
REQ-012 Avg_Valid  output  1  one-cycle strobe when Avg_Propagation updates.
REQ-013 Min_Propagation / Max_Propagation  output  16 each  extremes of accepted samples since clear.
REQ-014 Sample_Count  output  16  accepted samples since clear, saturating.
REQ-015 Window_Error  output  1  sticky; a sample fell outside [Low_Limit, High_Limit].
REQ-016 Timeout_Error  output  1  sticky; no Done within TIMEOUT_CYCLES of a trigger.
REQ-017 Busy  output  1  high while in WAIT_DONE.

Function
REQ-018 Trigger and Done inputs SHALL each be registered once; rising edge = current & ~registered; no extra synchronizers (inputs are clk-domain).
REQ-019 FSM states: IDLE, WAIT_DONE, CAPTURE; reset state IDLE.
REQ-020 IDLE -> WAIT_DONE on trigger rising edge; timeout counter loads 0.
REQ-021 WAIT_DONE: timeout counter increments each cycle; Done rising edge -> CAPTURE; Pulser_IC_Error high -> IDLE, no sample, no flag; counter reaching TIMEOUT_CYCLES-1 -> IDLE, Timeout_Error set.
REQ-022 Priority in WAIT_DONE same cycle: Pulser_IC_Error > Done edge > timeout; a new trigger edge restarts the timeout counter at 0 and stays in WAIT_DONE.
REQ-023 CAPTURE lasts exactly one cycle: samples Pulse_Propagation_Counter, then -> IDLE (trigger edge in CAPTURE cycle is honoured: -> WAIT_DONE).
REQ-024 Sample outside window (value < Low_Limit or > High_Limit) SHALL set Window_Error and be discarded from all statistics.
REQ-025 Accepted sample: accumulator (16+AVG_LOG2 bits, no overflow possible) adds value; block counter increments; Min/Max update; Sample_Count increments, saturating at 16'hFFFF.
REQ-026 When block counter reaches 2^AVG_LOG2 accepted samples: Avg_Propagation = accumulator >> AVG_LOG2 (truncate) registered 1 cycle after the CAPTURE, Avg_Valid pulses that same cycle, accumulator and block counter clear.
REQ-027 Min initial 16'hFFFF, Max initial 16'h0000; both report these until the first accepted sample.
REQ-028 Done rising edge outside WAIT_DONE SHALL be ignored.
REQ-029 Stats_Clear: clears accumulator, block counter, Sample_Count, Min/Max to initial values, Window_Error, Timeout_Error; does not change FSM state or Avg_Propagation; a capture in the same cycle is dropped; a flag-setting event in the same cycle wins (flag set).

Reset
REQ-030 While reset high: FSM IDLE, all counters and accumulator 0, Avg_Propagation 0, Avg_Valid 0, Min 16'hFFFF, Max 0, Sample_Count 0, both error flags 0, Busy 0, edge registers 0.
REQ-031 Reset asserted mid-measurement SHALL abort it with no sample, flag or strobe after release.

Verification
REQ-032 AVG_LOG2=3, window 0..FFFF, 8 trigger/Done pairs with counts 100..107 -> single Avg_Valid, Avg=103, Min=100, Max=107, Sample_Count=8.
REQ-033 Window 50..200, sample 201 then 120 -> Window_Error=1, Sample_Count=1, Min=Max=120.
REQ-034 TIMEOUT_CYCLES=20, trigger with no Done -> Timeout_Error at cycle 20 after edge, Busy low; later Done ignored.
REQ-035 Pulser_IC_Error and Done edge same cycle in WAIT_DONE -> no sample, no flags, IDLE.
REQ-036 Stats_Clear after 5 samples, then 8 samples 10 each -> Avg=10 after 8th only, Sample_Count=8.
REQ-037 Reset pulse during WAIT_DONE -> all outputs at reset values; next trigger/Done 77 -> Sample_Count=1, Min=Max=77.
